// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface addsub_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             AS;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ov;

  modport master (output start, A, B, AS, input busy, done, S, Cout, Ov);
  modport slave  (input start, A, B, AS, output busy, done, S, Cout, Ov);
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub, DIGIT bits per cycle, LSB first.
// Optional saturation on signed overflow: define ADDSUB_SERIAL_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit per clock through the shared slice
// DONE  | result valid, done pulse; start here chains the next op
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  addsub_serial_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "addsub_serial: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
`ifdef ADDSUB_SERIAL_SAT_EN
  logic             a_msb;
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [DIGIT:0]       slice;
  logic [DIGIT-1:0]     dsum;
  logic                 c_next;
  logic                 c_into_msb;
  logic [WIDTH+DIGIT-1:0] sr_cat;
  logic [WIDTH-1:0]     sum_next;
  logic                 last;

  always_comb begin
    slice      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    dsum       = slice[DIGIT-1:0];
    c_next     = slice[DIGIT];
    // carry into the top bit of the slice, recovered from its sum bit
    c_into_msb = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
    sr_cat     = {dsum, sum_sr};
    sum_next   = sr_cat[WIDTH+DIGIT-1:DIGIT];
    last       = (cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      sum_sr   <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
      bus.Ov   <= 1'b0;
`ifdef ADDSUB_SERIAL_SAT_EN
      a_msb    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.A;
            op_b     <= bus.B ^ {WIDTH{bus.AS}};
            carry    <= bus.AS;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
`ifdef ADDSUB_SERIAL_SAT_EN
            a_msb    <= bus.A[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          carry  <= c_next;
          sum_sr <= sum_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.Cout <= c_next;
            bus.Ov   <= c_into_msb ^ c_next;
`ifdef ADDSUB_SERIAL_SAT_EN
            if (c_into_msb ^ c_next)
              bus.S <= a_msb ? S_MIN : S_MAX;
            else
              bus.S <= sum_next;
`else
            bus.S    <= sum_next;
`endif
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Randomized self-checking bench: DIGIT=1 and DIGIT=4 instances against an arithmetic model.
module tb_addsub_serial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(8)) if1 ();
  addsub_serial_if #(.WIDTH(8)) if4 ();

  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_s [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // returns {cout, ov, s}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic as_);
    int sa, sb, r, u;
    logic [7:0] s;
    logic ov, co;
    sa = $signed(a);
    sb = $signed(b);
    r  = as_ ? sa - sb : sa + sb;
    u  = as_ ? int'(a) + 256 - int'(b) : int'(a) + int'(b);
    ov = (r > 127) || (r < -128);
    co = (u >= 256);
    s  = 8'(u);
`ifdef ADDSUB_SERIAL_SAT_EN
    if (ov) s = a[7] ? 8'h80 : 8'h7F;
`endif
    return {co, ov, s};
  endfunction

  function automatic logic rd_done(input int w); return w ? if4.done : if1.done; endfunction
  function automatic logic rd_busy(input int w); return w ? if4.busy : if1.busy; endfunction
  function automatic logic rd_cout(input int w); return w ? if4.Cout : if1.Cout; endfunction
  function automatic logic rd_ov(input int w);   return w ? if4.Ov   : if1.Ov;   endfunction
  function automatic logic [7:0] rd_s(input int w); return w ? if4.S : if1.S; endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b, input logic as_);
    if (w != 0) begin
      if4.start = st; if4.A = a; if4.B = b; if4.AS = as_;
    end else begin
      if1.start = st; if1.A = a; if1.B = b; if1.AS = as_;
    end
  endtask

  // called #1 after a rising edge; returns #1 after the sampling edge
  task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic as_);
    drive(w, 1'b1, a, b, as_);
    @(posedge clk); #1;
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic wait_check(input int w, input logic [7:0] a, input logic [7:0] b, input logic as_,
                            input bit keep, input string tag);
    int lat = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    logic [9:0] e;
    int n;
    e = model(a, b, as_);
    n = (w != 0) ? 2 : 8;
    while (!rd_done(w) && lat <= 20) begin
      if (!rd_busy(w)) busy_ok = 1'b0;
      if (rd_s(w) !== last_s[w]) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, n);
    chk({tag, " busy_during_run"}, busy_ok, 1);
    chk({tag, " s_held"}, hold_ok, 1);
    chk({tag, " S"}, rd_s(w), e[7:0]);
    chk({tag, " Cout"}, rd_cout(w), e[9]);
    chk({tag, " Ov"}, rd_ov(w), e[8]);
    chk({tag, " busy_at_done"}, rd_busy(w), 0);
    last_s[w] = e[7:0];
    if (!keep) begin
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, rd_done(w), 0);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic as_; } vec_t;
  vec_t dir [5];

  initial begin
    bit no_done;
    logic [7:0] ra, rb;
    logic ras;
    bit k;
    dir[0] = '{8'h06, 8'h01, 1'b0};
    dir[1] = '{8'h02, 8'h0F, 1'b1};
    dir[2] = '{8'h80, 8'h01, 1'b1};
    dir[3] = '{8'h7F, 8'h01, 1'b0};
    dir[4] = '{8'hFF, 8'h01, 1'b0};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("reset S", rd_s(w), 0);
      chk("reset Cout", rd_cout(w), 0);
      chk("reset Ov", rd_ov(w), 0);
      chk("reset busy", rd_busy(w), 0);
      chk("reset done", rd_done(w), 0);
      last_s[w] = 8'h00;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 5; i++) begin
        start_op(w, dir[i].a, dir[i].b, dir[i].as_);
        wait_check(w, dir[i].a, dir[i].b, dir[i].as_, 1'b0, "directed");
      end

    // back-to-back: new start in the DONE cycle
    start_op(0, 8'h55, 8'h33, 1'b0);
    wait_check(0, 8'h55, 8'h33, 1'b0, 1'b1, "b2b_first");
    start_op(0, 8'h12, 8'hF0, 1'b1);
    chk("b2b busy_reassert", rd_busy(0), 1);
    chk("b2b done_cleared", rd_done(0), 0);
    wait_check(0, 8'h12, 8'hF0, 1'b1, 1'b0, "b2b_second");

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 30; i++) begin
        ra  = 8'($urandom);
        rb  = 8'($urandom);
        ras = 1'($urandom);
        k   = bit'($urandom_range(0, 1));
        start_op(w, ra, rb, ras);
        wait_check(w, ra, rb, ras, k, "random");
      end
    @(posedge clk); #1;

    // abort: second start at k+3 ignored, reset at k+5 drops the op
    start_op(0, 8'h7F, 8'h01, 1'b0);
    wait_check(0, 8'h7F, 8'h01, 1'b0, 1'b0, "pre_abort");
    start_op(0, 8'h11, 8'h22, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 1'b1, 8'h44, 8'h55, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort S", rd_s(0), 0);
    chk("abort Cout", rd_cout(0), 0);
    chk("abort Ov", rd_ov(0), 0);
    chk("abort busy", rd_busy(0), 0);
    chk("abort done", rd_done(0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_s[0] = 8'h00;
    last_s[1] = 8'h00;
    no_done = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (rd_done(0) || rd_busy(0)) no_done = 1'b0;
    end
    chk("abort no_done_after_reset", no_done, 1);

    start_op(0, 8'h80, 8'h80, 1'b0);
    wait_check(0, 8'h80, 8'h80, 1'b0, 1'b0, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
